// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control unit for the RV32I core. It walks the datapath through
// IF/ID/EX/MEM/WB and holds a private instruction register that is loaded on
// the edge leaving IF. Illegal instructions either lock the unit in a sticky
// TRAP state or retire as a NOP, depending on TRAP_ON_ILLEGAL.
//
// Parameters
//   MEM_HANDSHAKE   : 1 = MEM waits for dReady, 0 = MEM lasts MEM_LATENCY cycles
//   MEM_LATENCY     : MEM cycles in fixed mode (values below 1 act as 1)
//   ENABLE_IMM_ALU  : 1 = opcode 0010011 is legal
//   TRAP_ON_ILLEGAL : 1 = illegal enters TRAP, 0 = illegal retires as NOP
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   instr    in   instruction word, sampled only in IF
//   Zero     in   ALU result is zero
//   Lt       in   ALU signed less-than
//   dReady   in   data memory done (handshake mode only)
//   ALUCtrl  out  ALU operation
//   ALUSrc   out  1 = immediate operand
//   MemRead  out  data read strobe
//   MemWrite out  data write strobe
//   MemToReg out  1 = write back memory data
//   RegWrite out  register file write enable
//   loadPC   out  PC update strobe
//   PCSrc    out  1 = branch target
//   state    out  IF=0 ID=1 EX=2 MEM=3 WB=4 TRAP=5
//   illegal  out  illegal-instruction flag
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_HANDSHAKE   = 0,
    parameter int MEM_LATENCY     = 1,
    parameter int ENABLE_IMM_ALU  = 1,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        Lt,
    input  logic        dReady,
    output logic [3:0]  ALUCtrl,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        loadPC,
    output logic        PCSrc,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam int EFF_LAT = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
    localparam int CNT_W   = (EFF_LAT > 1) ? $clog2(EFF_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EFF_LAT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    state_t           r_state;
    state_t           w_nextState;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_isR;
    logic       w_isI;
    logic       w_isLoad;
    logic       w_isStore;
    logic       w_isBranch;
    logic       w_legal;
    logic       w_taken;
    logic [3:0] w_aluOp;
    logic       w_unused;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];
    // Register and immediate fields belong to the datapath, not to control.
    assign w_unused = ^{r_ir[24:15], r_ir[11:7]};

    // State, instruction register and MEM wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_ir    <= 32'h0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IF) begin
                r_ir <= instr;
            end
            // Counter starts from zero on every MEM entry.
            if (r_state == S_EX) begin
                r_cnt <= '0;
            end else if (MEM_HANDSHAKE == 0 && r_state == S_MEM && w_nextState == S_MEM) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Instruction class and ALU operation from the instruction register.
    // SLTU/SLTIU have no dedicated ALU code and share the SLT encoding.
    always_comb begin
        w_isR      = 1'b0;
        w_isI      = 1'b0;
        w_isLoad   = 1'b0;
        w_isStore  = 1'b0;
        w_isBranch = 1'b0;
        w_aluOp    = ALU_ILL;
        case (w_opcode)
            OP_R: begin
                if (w_funct7 == 7'b0000000 ||
                    (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                    w_isR = 1'b1;
                    case (w_funct3)
                        3'b000:         w_aluOp = w_funct7[5] ? ALU_SUB : ALU_ADD;
                        3'b001:         w_aluOp = ALU_SLL;
                        3'b010, 3'b011: w_aluOp = ALU_SLT;
                        3'b100:         w_aluOp = ALU_XOR;
                        3'b101:         w_aluOp = w_funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:         w_aluOp = ALU_OR;
                        default:        w_aluOp = ALU_AND;
                    endcase
                end
            end
            OP_IMM: begin
                if (ENABLE_IMM_ALU != 0 && (w_funct3 != 3'b001 || w_funct7 == 7'b0000000)) begin
                    w_isI = 1'b1;
                    case (w_funct3)
                        3'b000:         w_aluOp = ALU_ADD;
                        3'b001:         w_aluOp = ALU_SLL;
                        3'b010, 3'b011: w_aluOp = ALU_SLT;
                        3'b100:         w_aluOp = ALU_XOR;
                        3'b101:         w_aluOp = r_ir[30] ? ALU_SRA : ALU_SRL;
                        3'b110:         w_aluOp = ALU_OR;
                        default:        w_aluOp = ALU_AND;
                    endcase
                end
            end
            OP_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    w_isLoad = 1'b1;
                    w_aluOp  = ALU_ADD;
                end
            end
            OP_STORE: begin
                if (w_funct3 == 3'b010) begin
                    w_isStore = 1'b1;
                    w_aluOp   = ALU_ADD;
                end
            end
            OP_BRANCH: begin
                case (w_funct3)
                    3'b000, 3'b001, 3'b100, 3'b101: begin
                        w_isBranch = 1'b1;
                        w_aluOp    = ALU_SUB;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign w_legal = w_isR | w_isI | w_isLoad | w_isStore | w_isBranch;

    // Branch condition: BEQ, BNE, BLT, BGE.
    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = ~Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = ~Lt;
            default: w_taken = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IF: w_nextState = S_ID;
            S_ID: begin
                if (w_legal) begin
                    w_nextState = S_EX;
                end else if (TRAP_ON_ILLEGAL != 0) begin
                    w_nextState = S_TRAP;
                end else begin
                    w_nextState = S_WB;
                end
            end
            S_EX: w_nextState = (w_isLoad || w_isStore) ? S_MEM : S_WB;
            S_MEM: begin
                if (MEM_HANDSHAKE != 0) begin
                    if (dReady) begin
                        w_nextState = S_WB;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_nextState = S_WB;
                end
            end
            S_WB:    w_nextState = S_IF;
            S_TRAP:  w_nextState = S_TRAP;
            default: w_nextState = S_IF;
        endcase
    end

    // Control outputs; everything is zero in IF and, apart from the flag, in TRAP.
    always_comb begin
        ALUCtrl  = 4'b0000;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        loadPC   = 1'b0;
        PCSrc    = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_ID: begin
                ALUCtrl = w_aluOp;
                ALUSrc  = w_isLoad | w_isStore | w_isI;
                illegal = ~w_legal;
            end
            S_EX: begin
                ALUCtrl = w_aluOp;
                ALUSrc  = w_isLoad | w_isStore | w_isI;
            end
            S_MEM: begin
                ALUCtrl  = w_aluOp;
                ALUSrc   = w_isLoad | w_isStore | w_isI;
                MemRead  = w_isLoad;
                MemWrite = w_isStore;
                MemToReg = w_isLoad;
            end
            S_WB: begin
                ALUCtrl  = w_aluOp;
                ALUSrc   = w_isLoad | w_isStore | w_isI;
                MemToReg = w_isLoad;
                RegWrite = w_isR | w_isI | w_isLoad;
                loadPC   = 1'b1;
                PCSrc    = w_isBranch & w_taken;
                // Only reachable with an illegal IR when it retires as a NOP.
                illegal  = ~w_legal;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Three controller instances with their own inputs:
//   0 : handshake memory, imm ALU on, trap on illegal
//   1 : fixed 3-cycle memory, imm ALU on, trap on illegal
//   2 : MEM_LATENCY=0 (acts as 1), imm ALU off, illegal retires as NOP
// Directed scenarios use hand-written expectations; the random scenario uses
// an instruction-level schedule model built from the decode rules.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] aluCtrl;
        logic       aluSrc;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regWrite;
        logic       loadPC;
        logic       pcSrc;
        logic [2:0] state;
        logic       illegal;
    } outs_t;

    typedef struct {
        int         kind;
        logic [3:0] alu;
        logic [2:0] f3;
    } dec_t;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_ILL = 5;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SLT = 4'b0100;
    localparam logic [3:0] A_XOR = 4'b0101;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SRL = 4'b1000;
    localparam logic [3:0] A_SLL = 4'b1001;
    localparam logic [3:0] A_SRA = 4'b1010;
    localparam logic [3:0] A_ILL = 4'b1111;

    logic        clk;
    logic        rstS     [3];
    logic [31:0] instrS   [3];
    logic        zeroS    [3];
    logic        ltS      [3];
    logic        dReadyS  [3];
    logic [3:0]  aluCtrlW [3];
    logic        aluSrcW  [3];
    logic        memReadW [3];
    logic        memWriteW[3];
    logic        memToRegW[3];
    logic        regWriteW[3];
    logic        loadPCW  [3];
    logic        pcSrcW   [3];
    logic [2:0]  stateW   [3];
    logic        illegalW [3];

    int vectors;
    int miscompares;
    int cfgHs     [3];
    int cfgImm    [3];
    int cfgTrap   [3];
    int cfgEffLat [3];

    for (genvar g = 0; g < 3; g++) begin : gDut
        multicycle_ctrl #(
            .MEM_HANDSHAKE  (g == 0 ? 1 : 0),
            .MEM_LATENCY    (g == 1 ? 3 : (g == 2 ? 0 : 1)),
            .ENABLE_IMM_ALU (g == 2 ? 0 : 1),
            .TRAP_ON_ILLEGAL(g == 2 ? 0 : 1)
        ) uDut (
            .clk     (clk),
            .rst     (rstS[g]),
            .instr   (instrS[g]),
            .Zero    (zeroS[g]),
            .Lt      (ltS[g]),
            .dReady  (dReadyS[g]),
            .ALUCtrl (aluCtrlW[g]),
            .ALUSrc  (aluSrcW[g]),
            .MemRead (memReadW[g]),
            .MemWrite(memWriteW[g]),
            .MemToReg(memToRegW[g]),
            .RegWrite(regWriteW[g]),
            .loadPC  (loadPCW[g]),
            .PCSrc   (pcSrcW[g]),
            .state   (stateW[g]),
            .illegal (illegalW[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // flags order: {aluSrc, memRead, memWrite, memToReg, regWrite, loadPC, pcSrc}
    function automatic outs_t mk(input logic [3:0] alu, input logic [6:0] flags,
                                 input logic [2:0] st, input logic ill);
        outs_t o;
        o.aluCtrl  = alu;
        o.aluSrc   = flags[6];
        o.memRead  = flags[5];
        o.memWrite = flags[4];
        o.memToReg = flags[3];
        o.regWrite = flags[2];
        o.loadPC   = flags[1];
        o.pcSrc    = flags[0];
        o.state    = st;
        o.illegal  = ill;
        return o;
    endfunction

    function automatic outs_t sampleOut(input int g);
        outs_t o;
        o.aluCtrl  = aluCtrlW[g];
        o.aluSrc   = aluSrcW[g];
        o.memRead  = memReadW[g];
        o.memWrite = memWriteW[g];
        o.memToReg = memToRegW[g];
        o.regWrite = regWriteW[g];
        o.loadPC   = loadPCW[g];
        o.pcSrc    = pcSrcW[g];
        o.state    = stateW[g];
        o.illegal  = illegalW[g];
        return o;
    endfunction

    // Reference decode written as mnemonic tables.
    function automatic dec_t refDecode(input logic [31:0] ins, input int immEn);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op     = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        d.kind = K_ILL;
        d.alu  = A_ILL;
        d.f3   = f3;
        if (op == 7'b0110011) begin
            case ({f7, f3})
                {7'h00, 3'd0}: d.alu = A_ADD;
                {7'h20, 3'd0}: d.alu = A_SUB;
                {7'h00, 3'd1}: d.alu = A_SLL;
                {7'h00, 3'd2}: d.alu = A_SLT;
                {7'h00, 3'd3}: d.alu = A_SLT;
                {7'h00, 3'd4}: d.alu = A_XOR;
                {7'h00, 3'd5}: d.alu = A_SRL;
                {7'h20, 3'd5}: d.alu = A_SRA;
                {7'h00, 3'd6}: d.alu = A_OR;
                {7'h00, 3'd7}: d.alu = A_AND;
                default:       d.alu = A_ILL;
            endcase
            if (d.alu != A_ILL) d.kind = K_R;
        end else if (op == 7'b0010011 && immEn != 0) begin
            case (f3)
                3'd0: d.alu = A_ADD;
                3'd1: d.alu = (f7 == 7'h00) ? A_SLL : A_ILL;
                3'd2: d.alu = A_SLT;
                3'd3: d.alu = A_SLT;
                3'd4: d.alu = A_XOR;
                3'd5: d.alu = ins[30] ? A_SRA : A_SRL;
                3'd6: d.alu = A_OR;
                default: d.alu = A_AND;
            endcase
            if (d.alu != A_ILL) d.kind = K_I;
        end else if (op == 7'b0000011 && f3 == 3'd2) begin
            d.kind = K_LD;
            d.alu  = A_ADD;
        end else if (op == 7'b0100011 && f3 == 3'd2) begin
            d.kind = K_ST;
            d.alu  = A_ADD;
        end else if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)) begin
            d.kind = K_BR;
            d.alu  = A_SUB;
        end
        return d;
    endfunction

    function automatic logic refTaken(input logic [2:0] f3, input logic z, input logic lt);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs for one cycle, given the stage the instruction is in.
    function automatic outs_t expectOut(input int st, input dec_t d, input logic z, input logic lt);
        outs_t o;
        o       = '0;
        o.state = 3'(st);
        if (st >= 1 && st <= 4) begin
            o.aluCtrl = d.alu;
            o.aluSrc  = (d.kind == K_LD || d.kind == K_ST || d.kind == K_I);
        end
        if (st == 1) o.illegal = (d.kind == K_ILL);
        if (st == 5) o.illegal = 1'b1;
        if (st == 3) begin
            o.memRead  = (d.kind == K_LD);
            o.memWrite = (d.kind == K_ST);
            o.memToReg = (d.kind == K_LD);
        end
        if (st == 4) begin
            o.memToReg = (d.kind == K_LD);
            o.regWrite = (d.kind == K_R || d.kind == K_I || d.kind == K_LD);
            o.loadPC   = 1'b1;
            o.pcSrc    = (d.kind == K_BR) && refTaken(d.f3, z, lt);
            o.illegal  = (d.kind == K_ILL);
        end
        return o;
    endfunction

    function automatic logic [31:0] randomInstr();
        logic [31:0] r;
        int          pick;
        r    = $urandom();
        pick = $urandom_range(0, 9);
        case (pick)
            0, 1, 8: begin
                r[6:0] = 7'b0110011;
                if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            2, 9: begin
                r[6:0] = 7'b0010011;
                if ($urandom_range(0, 1) != 0) r[31:25] = {1'b0, r[30], 5'b00000};
            end
            3: begin
                r[6:0] = 7'b0000011;
                if ($urandom_range(0, 3) != 0) r[14:12] = 3'd2;
            end
            4: begin
                r[6:0] = 7'b0100011;
                if ($urandom_range(0, 3) != 0) r[14:12] = 3'd2;
            end
            5, 6: r[6:0] = 7'b1100011;
            default: ;
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs just after a rising edge, sample at the falling edge.
    task automatic runCycle(input int g, input logic [31:0] ins, input logic z, input logic lt,
                            input logic dr, input logic rs, output outs_t obs);
        instrS[g]  = ins;
        zeroS[g]   = z;
        ltS[g]     = lt;
        dReadyS[g] = dr;
        rstS[g]    = rs;
        @(negedge clk);
        obs = sampleOut(g);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int g);
        outs_t junk;
        runCycle(g, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, junk);
    endtask

    task automatic test_reset();
        outs_t obs;
        for (int g = 0; g < 3; g++) begin
            doReset(g);
            runCycle(g, 32'h002081B3, 1'b1, 1'b1, 1'b1, 1'b0, obs);
            vectors++;
            if (obs !== outs_t'(0)) begin
                miscompares++;
                $display("[TB] FAIL reset dut%0d: got %h want %h", g, obs, outs_t'(0));
            end
        end
    endtask

    task automatic test_add();
        outs_t exp [5];
        outs_t obs;
        exp[0] = '0;
        exp[1] = mk(A_ADD, 7'b0000000, 3'd1, 1'b0);
        exp[2] = mk(A_ADD, 7'b0000000, 3'd2, 1'b0);
        exp[3] = mk(A_ADD, 7'b0000110, 3'd4, 1'b0);
        exp[4] = '0;
        doReset(0);
        doReset(0);
        for (int i = 0; i < 5; i++) begin
            runCycle(0, 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL add cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_lw_handshake();
        outs_t exp [9];
        outs_t obs;
        int    readCnt;
        exp[0] = '0;
        exp[1] = mk(A_ADD, 7'b1000000, 3'd1, 1'b0);
        exp[2] = mk(A_ADD, 7'b1000000, 3'd2, 1'b0);
        for (int i = 3; i < 7; i++) exp[i] = mk(A_ADD, 7'b1101000, 3'd3, 1'b0);
        exp[7] = mk(A_ADD, 7'b1001110, 3'd4, 1'b0);
        exp[8] = '0;
        readCnt = 0;
        doReset(0);
        for (int i = 0; i < 9; i++) begin
            runCycle(0, (i == 0) ? 32'h0000A183 : 32'h0, 1'b0, 1'b0, (i == 6), 1'b0, obs);
            if (obs.memRead) readCnt++;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL lw_hs cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
        vectors++;
        if (readCnt !== 4) begin
            miscompares++;
            $display("[TB] FAIL lw_hs memRead cycles: got %0d want 4", readCnt);
        end
    endtask

    task automatic test_branch();
        outs_t exp [9];
        outs_t obs;
        exp[0] = '0;
        exp[1] = mk(A_SUB, 7'b0000000, 3'd1, 1'b0);
        exp[2] = mk(A_SUB, 7'b0000000, 3'd2, 1'b0);
        exp[3] = mk(A_SUB, 7'b0000011, 3'd4, 1'b0);
        exp[4] = '0;
        exp[5] = mk(A_SUB, 7'b0000000, 3'd1, 1'b0);
        exp[6] = mk(A_SUB, 7'b0000000, 3'd2, 1'b0);
        exp[7] = mk(A_SUB, 7'b0000010, 3'd4, 1'b0);
        exp[8] = '0;
        doReset(0);
        for (int i = 0; i < 9; i++) begin
            runCycle(0, (i == 0) ? 32'h00208463 : ((i == 4) ? 32'h00209463 : 32'h0),
                     1'b1, 1'b0, 1'b0, 1'b0, obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL branch cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_trap();
        outs_t exp;
        outs_t obs;
        doReset(0);
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || i == 14) exp = '0;
            else if (i == 1)       exp = mk(A_ILL, 7'b0000000, 3'd1, 1'b1);
            else                   exp = mk(4'b0000, 7'b0000000, 3'd5, 1'b1);
            runCycle(0, (i == 0) ? 32'hFFFFFFFF : $urandom(), 1'($urandom()), 1'($urandom()),
                     1'($urandom()), (i == 13), obs);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL trap cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_sw_fixed();
        outs_t exp [7];
        outs_t obs;
        int    writeCnt;
        exp[0] = '0;
        exp[1] = mk(A_ADD, 7'b1000000, 3'd1, 1'b0);
        exp[2] = mk(A_ADD, 7'b1000000, 3'd2, 1'b0);
        for (int i = 3; i < 6; i++) exp[i] = mk(A_ADD, 7'b1010000, 3'd3, 1'b0);
        exp[6] = mk(A_ADD, 7'b1000010, 3'd4, 1'b0);
        writeCnt = 0;
        doReset(1);
        for (int i = 0; i < 7; i++) begin
            runCycle(1, (i == 0) ? 32'h0020A023 : 32'h0, 1'b0, 1'b0, (i == 3), 1'b0, obs);
            if (obs.memWrite) writeCnt++;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL sw_fixed cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
        vectors++;
        if (writeCnt !== 3) begin
            miscompares++;
            $display("[TB] FAIL sw_fixed memWrite cycles: got %0d want 3", writeCnt);
        end
        // Reset lands in the second MEM cycle.
        doReset(1);
        for (int i = 0; i < 6; i++) begin
            runCycle(1, (i == 0) ? 32'h0020A023 : 32'h0, 1'b0, 1'b0, 1'b0, (i == 4), obs);
            vectors++;
            if (obs !== ((i == 5) ? outs_t'(0) : exp[i])) begin
                miscompares++;
                $display("[TB] FAIL sw_reset cyc%0d: got %h want %h", i, obs,
                         (i == 5) ? outs_t'(0) : exp[i]);
            end
        end
    endtask

    task automatic test_sub_ir();
        outs_t exp [5];
        outs_t obs;
        exp[0] = '0;
        exp[1] = mk(A_SUB, 7'b0000000, 3'd1, 1'b0);
        exp[2] = mk(A_SUB, 7'b0000000, 3'd2, 1'b0);
        exp[3] = mk(A_SUB, 7'b0000110, 3'd4, 1'b0);
        exp[4] = '0;
        doReset(0);
        for (int i = 0; i < 5; i++) begin
            runCycle(0, (i == 0) ? 32'h40208133 : 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL sub_ir cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_nop_illegal();
        outs_t exp [9];
        outs_t obs;
        exp[0] = '0;
        exp[1] = mk(A_ILL, 7'b0000000, 3'd1, 1'b1);
        exp[2] = mk(A_ILL, 7'b0000010, 3'd4, 1'b1);
        exp[3] = '0;
        exp[4] = mk(A_ADD, 7'b1000000, 3'd1, 1'b0);
        exp[5] = mk(A_ADD, 7'b1000000, 3'd2, 1'b0);
        exp[6] = mk(A_ADD, 7'b1101000, 3'd3, 1'b0);
        exp[7] = mk(A_ADD, 7'b1001110, 3'd4, 1'b0);
        exp[8] = '0;
        doReset(2);
        for (int i = 0; i < 9; i++) begin
            runCycle(2, (i == 0) ? 32'h00100093 : ((i == 3) ? 32'h0000A183 : 32'h0),
                     1'b0, 1'b0, 1'b0, 1'b0, obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL nop_illegal cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        outs_t exp [5];
        outs_t obs;
        exp[0] = '0;
        exp[1] = mk(A_ADD, 7'b1000000, 3'd1, 1'b0);
        exp[2] = mk(A_ADD, 7'b1000000, 3'd2, 1'b0);
        exp[3] = mk(A_ADD, 7'b1101000, 3'd3, 1'b0);
        exp[4] = '0;
        doReset(0);
        for (int i = 0; i < 5; i++) begin
            runCycle(0, (i == 0) ? 32'h0000A183 : 32'h0, 1'b0, 1'b0, (i == 3), (i == 3), obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL rst_priority cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_random(input int g, input int n);
        outs_t       obs;
        outs_t       exp;
        dec_t        d;
        logic [31:0] ins;
        int          sched[$];
        int          memLen;
        int          memIdx;
        int          rstAt;
        int          st;
        logic        z;
        logic        lt;
        logic        dr;
        logic        rs;
        doReset(g);
        for (int k = 0; k < n; k++) begin
            ins    = randomInstr();
            d      = refDecode(ins, cfgImm[g]);
            memLen = (cfgHs[g] != 0) ? $urandom_range(1, 4) : cfgEffLat[g];
            sched  = {};
            sched.push_back(0);
            sched.push_back(1);
            if (d.kind == K_ILL) begin
                if (cfgTrap[g] != 0) begin
                    for (int t = $urandom_range(3, 7); t > 0; t--) sched.push_back(5);
                end else begin
                    sched.push_back(4);
                end
            end else begin
                sched.push_back(2);
                if (d.kind == K_LD || d.kind == K_ST) begin
                    for (int m = 0; m < memLen; m++) sched.push_back(3);
                end
                sched.push_back(4);
            end
            rstAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, sched.size() - 1) : -1;
            if (sched[sched.size() - 1] == 5 && rstAt < 0) rstAt = sched.size() - 1;
            memIdx = 0;
            for (int c = 0; c < sched.size(); c++) begin
                st = sched[c];
                z  = 1'($urandom());
                lt = 1'($urandom());
                if (st == 3 && cfgHs[g] != 0) dr = (memIdx == memLen - 1);
                else                          dr = 1'($urandom());
                rs = (c == rstAt);
                runCycle(g, (c == 0) ? ins : $urandom(), z, lt, dr, rs, obs);
                exp = expectOut(st, d, z, lt);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL rand dut%0d instr %h cyc%0d: got %h want %h",
                             g, ins, c, obs, exp);
                end
                if (st == 3) memIdx++;
                if (rs) break;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cfgHs       = '{1, 0, 0};
        cfgImm      = '{1, 1, 0};
        cfgTrap     = '{1, 1, 0};
        cfgEffLat   = '{1, 3, 1};
        for (int g = 0; g < 3; g++) begin
            rstS[g]    = 1'b1;
            instrS[g]  = 32'h0;
            zeroS[g]   = 1'b0;
            ltS[g]     = 1'b0;
            dReadyS[g] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_lw_handshake();
        test_branch();
        test_trap();
        test_sw_fixed();
        test_sub_ir();
        test_nop_illegal();
        test_reset_priority();
        for (int g = 0; g < 3; g++) test_random(g, 80);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised multicycle control unit for the RV32I core. It drives the existing datapath control inputs through the IF/ID/EX/MEM/WB sequence. It extends the earlier controller with an internal instruction register, I-type ALU ops, BNE/BLT/BGE, configurable memory wait (fixed latency or ready handshake), and illegal-instruction detection with a trap state.

Parameters:
MEM_HANDSHAKE, 0, 1 = MEM waits for dReady; 0 = MEM lasts exactly MEM_LATENCY cycles
MEM_LATENCY, 1, MEM cycles when MEM_HANDSHAKE=0; values <1 treated as 1
ENABLE_IMM_ALU, 1, 1 = opcode 0010011 legal; 0 = illegal
TRAP_ON_ILLEGAL, 1, 1 = illegal enters sticky TRAP; 0 = illegal retires as NOP

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
instr  input  32  instruction word, valid in IF
Zero  input  1  ALU result == 0
Lt  input  1  ALU signed less-than flag
dReady  input  1  data memory done (used only if MEM_HANDSHAKE=1)
ALUCtrl  output  4  ALU op
ALUSrc  output  1  1 = immediate operand
MemRead  output  1  data read strobe
MemWrite  output  1  data write strobe
MemToReg  output  1  1 = write back memory data
RegWrite  output  1  register file write enable
loadPC  output  1  PC update strobe
PCSrc  output  1  1 = branch target
state  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5
illegal  output  1  illegal-instruction flag

Behaviour:
- Reset: state=IF, IR=0, wait counter=0. All outputs are 0 in IF.
- IR loads instr on the clock edge that leaves IF. All decode uses IR only; instr is ignored outside IF.
- Outputs are combinational from (state, IR, Zero, Lt). State, IR and counter are the only registers.
- Transitions:
  - IF->ID, ID->EX.
  - ID->TRAP if the instruction is illegal and TRAP_ON_ILLEGAL=1.
  - ID->WB if the instruction is illegal and TRAP_ON_ILLEGAL=0 (NOP: loadPC only).
  - EX->MEM for load/store. EX->WB for R, I and branch.
  - MEM->WB per the wait rule. WB->IF.
  - TRAP->TRAP until rst.
- Wait rule:
  - Handshake mode: leave MEM on the edge where dReady=1. dReady=1 in the first MEM cycle gives 1 MEM cycle.
  - Fixed mode: counter clears on MEM entry and exits after MEM_LATENCY cycles.
- Cycles per instruction: R/I/branch = 4. Load/store = 4 + MEM cycles. Illegal-NOP = 3.
- Decode:
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LW (funct3=010 only), 0100011 SW (funct3=010 only), 1100011 branch (funct3 000/001/100/101).
  - All other opcodes and funct3 values are illegal.
  - R-type: funct7 must be 0000000, or 0100000 with funct3 000/101; otherwise illegal.
  - I-type: funct3 101 uses instr[30] for SRAI; funct3 001 requires funct7=0000000.
- ALUCtrl (driven in ID/EX/MEM/WB; 0 in IF/TRAP):
  - AND 0000, OR 0001, ADD 0010, SLT 0100, XOR 0101, SUB 0110, SRL 1000, SLL 1001, SRA 1010, illegal 1111.
  - Load/store use ADD. All branches use SUB.
- ALUSrc = 1 for load, store and I-type, in ID..WB.
- MemRead = 1 for the whole MEM stay on load. MemWrite = 1 for the whole MEM stay on store.
- MemToReg = 1 for load in MEM and WB.
- WB:
  - loadPC = 1 for every non-TRAP instruction.
  - RegWrite = 1 for R, I and load.
  - PCSrc = 1 for taken branches only: BEQ Zero, BNE !Zero, BLT Lt, BGE !Lt.
- illegal:
  - TRAP_ON_ILLEGAL=1: 1 in ID for an illegal IR, and held 1 in TRAP.
  - TRAP_ON_ILLEGAL=0: 1 in ID and in the following WB.
- TRAP: all other outputs 0.
- rst mid-instruction (including MEM with a strobe high): the next cycle is IF and all strobes are 0. No partial writeback.
- rst has priority over every transition, including TRAP and pending dReady.

Test Plan:
1. rst 2 cycles, instr=0x002081B3 (add) -> state 0,1,2,4,0. WB: RegWrite=1, loadPC=1, ALUCtrl=0010, ALUSrc=0.
2. MEM_HANDSHAKE=1, instr=0x0000A183 (lw), dReady low 3 MEM cycles then high -> MemRead=1 for 4 cycles, MemToReg=1. WB: RegWrite=1. Total 8 cycles.
3. instr=0x00208463 (beq) with Zero=1 -> WB PCSrc=1, loadPC=1, ALUCtrl=0110. Then 0x00209463 (bne) with Zero=1 -> PCSrc=0.
4. instr=0xFFFFFFFF, TRAP_ON_ILLEGAL=1 -> illegal=1 in ID, state=5 for 10+ cycles, all strobes 0. rst -> IF.
5. MEM_HANDSHAKE=0, MEM_LATENCY=3, instr=0x0020A023 (sw):
   - Run A: MemWrite high exactly 3 cycles, WB RegWrite=0.
   - Run B: rst in the 2nd MEM cycle -> next state=0, MemWrite=0.
6. IF with instr=0x40208133 (sub), then instr=0 from ID on -> EX ALUCtrl=0110. WB RegWrite=1.
